// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter: IDLE/BUSY/WAIT/FREE grant protocol with a
// rotating priority pointer and a hold-timeout that forces release.
module bus_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned IDW      = 2,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           done,
    input  logic           dly,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] owner,
    output logic           busy,
    output logic           timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_WAIT,
        ST_FREE
    } state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [7:0]     hcnt_q, hcnt_d;
    logic           timeout_q, timeout_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           busy_q, busy_d;

    logic           win_vld;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] scan_idx;

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = IDW'((32'(ptr_q) + k) % N);
            if (!win_vld && req[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_FREE: begin
                if (win_vld) begin
                    state_d = ST_BUSY;
                    owner_d = win_idx;
                    ptr_d   = IDW'((32'(win_idx) + 1) % N);
                    hcnt_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                hcnt_d = hcnt_q + 8'd1;
                // done outranks the timeout on the same edge
                if (done) begin
                    state_d = dly ? ST_WAIT : ST_FREE;
                end else if (hcnt_q == HOLD_LAST) begin
                    state_d   = ST_FREE;
                    timeout_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!dly) begin
                    state_d = ST_FREE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_BUSY) || (state_d == ST_WAIT);
        gnt_d  = busy_d ? (N'(1) << owner_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            hcnt_q    <= '0;
            timeout_q <= 1'b0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            timeout_q <= timeout_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: inputs driven and outputs sampled on
// the falling edge, expected values written out by hand.
module tb_bus_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       dly;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int unsigned total;
    int unsigned bad;

    bus_rr_arbiter #(
        .N        (4),
        .IDW      (2),
        .MAX_HOLD (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .dly     (dly),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        dly   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] rr_all [9];
    logic [3:0] rr_alt [7];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        req   = 4'($urandom);
        done  = 1'($urandom);
        dly   = 1'($urandom);
        rr_all = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001};
        rr_alt = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010,
                   4'b0000, 4'b1000};

        // reset with random inputs
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_gnt",     32'(gnt),     32'h0);
        check_eq("rst_busy",    32'(busy),    32'h0);
        check_eq("rst_timeout", 32'(timeout), 32'h0);
        check_eq("rst_owner",   32'(owner),   32'h0);
        tick();
        req = '0; done = 1'b0; dly = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check_eq("idle_gnt",  32'(gnt),  32'h0);
        check_eq("idle_busy", 32'(busy), 32'h0);

        // single requester, done on 3rd grant cycle
        req = 4'b0001;
        tick(); check_eq("single_c1", 32'(gnt), 32'h1);
        check_eq("single_busy", 32'(busy), 32'h1);
        tick(); check_eq("single_c2", 32'(gnt), 32'h1);
        tick(); check_eq("single_c3", 32'(gnt), 32'h1);
        done = 1'b1;
        tick(); check_eq("single_free", 32'(gnt), 32'h0);
        check_eq("single_free_busy", 32'(busy), 32'h0);
        done = 1'b0;
        tick(); check_eq("single_regrant", 32'(gnt), 32'h1);
        check_eq("single_owner", 32'(owner), 32'h0);

        // round robin, all requesting
        do_reset();
        req = 4'b1111; done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_eq($sformatf("rr_all_%0d", i), 32'(gnt), 32'(rr_all[i]));
        end

        // round robin, alternate requesters 1 and 3
        do_reset();
        req = 4'b1010; done = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_eq($sformatf("rr_alt_%0d", i), 32'(gnt), 32'(rr_alt[i]));
        end
        tick();
        check_eq("rr_alt_owner_last", 32'(owner), 32'h3);

        // WAIT path
        do_reset();
        req = 4'b0001;
        tick(); check_eq("wait_busy0", 32'(gnt), 32'h1);
        done = 1'b1; dly = 1'b1;
        tick(); check_eq("wait_enter", 32'(gnt), 32'h1);
        done = 1'b0; req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq($sformatf("wait_gnt_%0d", i),  32'(gnt),  32'h1);
            check_eq($sformatf("wait_busy_%0d", i), 32'(busy), 32'h1);
        end
        dly = 1'b0;
        tick(); check_eq("wait_free", 32'(gnt), 32'h0);
        check_eq("wait_free_busy", 32'(busy), 32'h0);
        tick(); check_eq("wait_idle", 32'(gnt), 32'h0);
        tick(); check_eq("wait_idle2", 32'(busy), 32'h0);

        // timeout
        do_reset();
        req = 4'b0100;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_eq($sformatf("to_gnt_%0d", i), 32'(gnt), 32'h4);
            check_eq($sformatf("to_pulse_%0d", i), 32'(timeout), 32'h0);
        end
        tick();
        check_eq("to_fire",      32'(timeout), 32'h1);
        check_eq("to_fire_gnt",  32'(gnt),     32'h0);
        tick();
        check_eq("to_regrant",   32'(gnt),     32'h4);
        check_eq("to_clear",     32'(timeout), 32'h0);
        for (int i = 2; i <= 16; i++) begin
            tick();
            check_eq($sformatf("to2_gnt_%0d", i), 32'(gnt), 32'h4);
            if (i == 16) done = 1'b1;
        end
        tick();
        check_eq("to_done_wins",     32'(timeout), 32'h0);
        check_eq("to_done_wins_gnt", 32'(gnt),     32'h0);
        done = 1'b0; req = '0;
        tick();

        // reset in 2nd WAIT cycle
        do_reset();
        req = 4'b0100;
        tick(); check_eq("mr_busy", 32'(gnt), 32'h4);
        done = 1'b1; dly = 1'b1;
        tick(); check_eq("mr_wait1", 32'(gnt), 32'h4);
        done = 1'b0;
        tick(); check_eq("mr_wait2", 32'(gnt), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mr_gnt",   32'(gnt),   32'h0);
        check_eq("mr_busy0", 32'(busy),  32'h0);
        check_eq("mr_owner", 32'(owner), 32'h0);
        req = 4'b1000; dly = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); check_eq("mr_first", 32'(gnt), 32'h8);
        check_eq("mr_first_owner", 32'(owner), 32'h3);

        // pointer restarts at 0 after a reset that follows a grant to index 2
        done = 1'b1;
        req  = 4'b0100;
        tick(); tick(); check_eq("ptr_pre", 32'(gnt), 32'h4);
        rst_n = 1'b0;
        req = 4'b1100; done = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); check_eq("ptr_restart", 32'(gnt), 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
